// File: rtl/imem_loader.sv
// imem_loader: packs RV32I instruction fields into 32-bit words and writes
// them to instruction memory at consecutive word addresses during program load.
module imem_loader #(
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_cls,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, FULL, ERR} state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_IA  = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // last word index; the write of this word fills the memory
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'((1 << ADDR_W) - 1);

    state_t             state;
    logic [31:0]        enc;
    logic [1:0]         chk;
    logic signed [31:0] simm;

    assign simm = in_imm;

    // encode the presented bundle and classify it (chk==0 means legal);
    // class is decided first, then range, then alignment
    always_comb begin
        enc = 32'h0;
        chk = 2'd0;
        case (in_cls)
            3'd0: begin
                enc = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LW};
                if (simm < -2048 || simm > 2047) chk = 2'd2;
            end
            3'd1: begin
                enc = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OP_SW};
                if (simm < -2048 || simm > 2047) chk = 2'd2;
            end
            3'd2: begin
                enc = {1'b0, in_funct7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
            end
            3'd3: begin
                enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:1], in_imm[11], OP_BR};
                if (simm < -4096 || simm > 4094) chk = 2'd2;
                else if (in_imm[0])               chk = 2'd3;
            end
            3'd4: begin
                enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IA};
                if (simm < -2048 || simm > 2047) chk = 2'd2;
            end
            3'd5: begin
                enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
                if (simm < -1048576 || simm > 1048574) chk = 2'd2;
                else if (in_imm[0])                     chk = 2'd3;
            end
            default: chk = 2'd1;
        endcase
    end

    // load FSM with registered outputs; start overrides everything but reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            count     <= '0;
            full      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'd0;
        end else if (start) begin
            state    <= LOAD;
            in_ready <= 1'b1;
            mem_we   <= 1'b0;
            count    <= '0;
            full     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b0;
                    mem_we   <= 1'b0;
                end
                LOAD: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (chk != 2'd0) begin
                            state    <= ERR;
                            err      <= 1'b1;
                            err_code <= chk;
                        end else begin
                            state     <= WRITE;
                            mem_we    <= 1'b1;
                            mem_addr  <= BASE_ADDR + (32'(count) << 2);
                            mem_wdata <= enc;
                        end
                    end else if (finish) begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                    end
                end
                WRITE: begin
                    mem_we <= 1'b0;
                    count  <= count + (ADDR_W+1)'(1);
                    if (count == LAST) begin
                        state    <= FULL;
                        full     <= 1'b1;
                        in_ready <= 1'b0;
                    end else begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                    end
                end
                FULL, ERR: begin
                    in_ready <= 1'b0;
                    mem_we   <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    mem_we   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader built with a 4-word memory (ADDR_W=2).
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset, start, finish, in_valid;
    logic        in_ready;
    logic [2:0]  in_cls, in_funct3;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic        in_funct7b5;
    logic [31:0] in_imm;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  count;
    logic        full, err;
    logic [1:0]  err_code;

    int ncmp = 0;
    int nbad = 0;

    imem_loader #(.ADDR_W(2), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_cls(in_cls),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_imm(in_imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .full(full), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic set_fields(input logic [2:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                              input logic [31:0] imm);
        in_cls = c; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7b5 = f7; in_imm = imm;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // present one bundle for a single cycle; returns 1 ns after the capture edge
    task automatic present();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; finish = 0; in_valid = 0;
        set_fields(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        ncmp++; if (in_ready !== 1'b0) begin nbad++; $display("FAIL rst_ready got=%0h exp=0", in_ready); end
        ncmp++; if (mem_we !== 1'b0) begin nbad++; $display("FAIL rst_we got=%0h exp=0", mem_we); end
        ncmp++; if (count !== 3'd0) begin nbad++; $display("FAIL rst_count got=%0d exp=0", count); end
        ncmp++; if ({full, err, err_code} !== 4'b0) begin nbad++; $display("FAIL rst_flags got=%b exp=0000", {full, err, err_code}); end
        ncmp++; if ({mem_addr, mem_wdata} !== 64'h0) begin nbad++; $display("FAIL rst_bus got=%h exp=0", {mem_addr, mem_wdata}); end
        reset = 1'b0;
        @(posedge clk); #1;
        ncmp++; if (in_ready !== 1'b0) begin nbad++; $display("FAIL idle_ready got=%0h exp=0", in_ready); end
    endtask

    task automatic test_lw();
        pulse_start();
        ncmp++; if (in_ready !== 1'b1) begin nbad++; $display("FAIL lw_ready got=%0h exp=1", in_ready); end
        set_fields(0, 5, 2, 0, 0, 0, 32'd8);
        present();
        ncmp++; if (mem_we !== 1'b1) begin nbad++; $display("FAIL lw_we got=%0h exp=1", mem_we); end
        ncmp++; if (mem_addr !== 32'h0) begin nbad++; $display("FAIL lw_addr got=%h exp=0", mem_addr); end
        ncmp++; if (mem_wdata !== 32'h00812283) begin nbad++; $display("FAIL lw_wdata got=%h exp=00812283", mem_wdata); end
        @(posedge clk); #1;
        ncmp++; if (mem_we !== 1'b0) begin nbad++; $display("FAIL lw_we_drop got=%0h exp=0", mem_we); end
        ncmp++; if (count !== 3'd1) begin nbad++; $display("FAIL lw_count got=%0d exp=1", count); end
        ncmp++; if (mem_wdata !== 32'h00812283) begin nbad++; $display("FAIL lw_hold got=%h exp=00812283", mem_wdata); end
    endtask

    task automatic test_back_to_back();
        pulse_start();
        set_fields(2, 3, 1, 2, 0, 0, 0);
        present();
        ncmp++; if ({mem_we, in_ready} !== 2'b10) begin nbad++; $display("FAIL r_we_ready got=%b exp=10", {mem_we, in_ready}); end
        ncmp++; if (mem_wdata !== 32'h002081B3) begin nbad++; $display("FAIL r_wdata got=%h exp=002081B3", mem_wdata); end
        set_fields(1, 0, 0, 6, 0, 0, 32'd4);
        @(posedge clk); #1;
        ncmp++; if ({mem_we, in_ready} !== 2'b01) begin nbad++; $display("FAIL r_load got=%b exp=01", {mem_we, in_ready}); end
        present();
        ncmp++; if ({mem_we, in_ready} !== 2'b10) begin nbad++; $display("FAIL sw_we_ready got=%b exp=10", {mem_we, in_ready}); end
        ncmp++; if (mem_addr !== 32'h4) begin nbad++; $display("FAIL sw_addr got=%h exp=4", mem_addr); end
        ncmp++; if (mem_wdata !== 32'h00602223) begin nbad++; $display("FAIL sw_wdata got=%h exp=00602223", mem_wdata); end
        @(posedge clk); #1;
        ncmp++; if (count !== 3'd2) begin nbad++; $display("FAIL sw_count got=%0d exp=2", count); end
    endtask

    task automatic test_encodings();
        pulse_start();
        set_fields(3, 0, 1, 1, 0, 0, -32'sd4);
        present();
        ncmp++; if (mem_wdata !== 32'hFE108EE3) begin nbad++; $display("FAIL br_wdata got=%h exp=FE108EE3", mem_wdata); end
        @(posedge clk); #1;
        set_fields(1, 0, 0, 0, 0, 0, -32'sd2048);
        present();
        ncmp++; if ({mem_we, mem_wdata} !== {1'b1, 32'h80002023}) begin nbad++; $display("FAIL sw_min got=%h exp=180002023", {mem_we, mem_wdata}); end
        @(posedge clk); #1;
        set_fields(5, 0, 0, 0, 0, 0, -32'sd2);
        present();
        ncmp++; if ({mem_we, mem_wdata} !== {1'b1, 32'hFFFFF06F}) begin nbad++; $display("FAIL jal_wdata got=%h exp=1FFFFF06F", {mem_we, mem_wdata}); end
        @(posedge clk); #1;
        pulse_start();
        set_fields(4, 7, 3, 0, 3'b111, 0, 32'd2047);
        present();
        ncmp++; if ({mem_we, mem_wdata} !== {1'b1, 32'h7FF1F393}) begin nbad++; $display("FAIL ialu_wdata got=%h exp=17FF1F393", {mem_we, mem_wdata}); end
        @(posedge clk); #1;
    endtask

    task automatic test_errors();
        pulse_start();
        set_fields(3, 0, 1, 1, 0, 0, 32'd4096);
        present();
        ncmp++; if ({mem_we, err, err_code} !== 4'b0110) begin nbad++; $display("FAIL br_range got=%b exp=0110", {mem_we, err, err_code}); end
        ncmp++; if (in_ready !== 1'b0) begin nbad++; $display("FAIL err_ready got=%0h exp=0", in_ready); end
        set_fields(0, 1, 0, 0, 0, 0, 0);
        present();
        ncmp++; if ({mem_we, count} !== 4'b0000) begin nbad++; $display("FAIL err_hold got=%b exp=0000", {mem_we, count}); end
        pulse_start();
        ncmp++; if ({err, err_code, in_ready} !== 4'b0001) begin nbad++; $display("FAIL err_clear got=%b exp=0001", {err, err_code, in_ready}); end
        set_fields(5, 0, 0, 0, 0, 0, 32'd3);
        present();
        ncmp++; if ({mem_we, err, err_code} !== 4'b0111) begin nbad++; $display("FAIL jal_align got=%b exp=0111", {mem_we, err, err_code}); end
        pulse_start();
        set_fields(7, 0, 0, 0, 0, 0, 0);
        present();
        ncmp++; if ({mem_we, err, err_code} !== 4'b0101) begin nbad++; $display("FAIL cls7 got=%b exp=0101", {mem_we, err, err_code}); end
        pulse_start();
        set_fields(4, 0, 0, 0, 0, 0, 32'd2048);
        present();
        ncmp++; if ({mem_we, err, err_code} !== 4'b0110) begin nbad++; $display("FAIL ialu_range got=%b exp=0110", {mem_we, err, err_code}); end
        pulse_start();
        set_fields(3, 0, 0, 0, 0, 0, 32'd4095);
        present();
        ncmp++; if ({err, err_code} !== 3'b110) begin nbad++; $display("FAIL br_4095 got=%b exp=110", {err, err_code}); end
    endtask

    task automatic test_full();
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            set_fields(0, 1, 0, 0, 0, 0, 0);
            present();
            ncmp++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'(i * 4), 32'h00002083}) begin
                nbad++; $display("FAIL full_wr%0d got=%h exp=1%h00002083", i, {mem_we, mem_addr, mem_wdata}, 32'(i * 4));
            end
            @(posedge clk); #1;
        end
        ncmp++; if ({count, full, in_ready} !== 5'b10010) begin nbad++; $display("FAIL full_state got=%b exp=10010", {count, full, in_ready}); end
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            ncmp++; if ({mem_we, count} !== 4'b0100) begin nbad++; $display("FAIL full_ignore%0d got=%b exp=0100", i, {mem_we, count}); end
        end
        in_valid = 1'b0;
        pulse_start();
        ncmp++; if ({count, full, in_ready} !== 5'b00001) begin nbad++; $display("FAIL full_restart got=%b exp=00001", {count, full, in_ready}); end
    endtask

    task automatic test_start_finish();
        pulse_start();
        set_fields(0, 1, 0, 0, 0, 0, 0);
        present();
        @(posedge clk); #1;
        in_valid = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b0;
        ncmp++; if ({mem_we, count, in_ready} !== 5'b00001) begin nbad++; $display("FAIL start_prio got=%b exp=00001", {mem_we, count, in_ready}); end
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
        ncmp++; if (in_ready !== 1'b0) begin nbad++; $display("FAIL finish_ready got=%0h exp=0", in_ready); end
        present();
        ncmp++; if (mem_we !== 1'b0) begin nbad++; $display("FAIL idle_ignore got=%0h exp=0", mem_we); end
    endtask

    task automatic test_reset_mid_write();
        pulse_start();
        set_fields(0, 1, 0, 0, 0, 0, 0);
        present();
        @(posedge clk); #1;
        present();
        ncmp++; if ({mem_we, count} !== 4'b1001) begin nbad++; $display("FAIL mid_pre got=%b exp=1001", {mem_we, count}); end
        #2 reset = 1'b1;
        #1;
        ncmp++; if ({mem_we, count, in_ready} !== 5'b00000) begin nbad++; $display("FAIL mid_async got=%b exp=00000", {mem_we, count, in_ready}); end
        #2 reset = 1'b0;
        @(posedge clk); #1;
        ncmp++; if ({mem_we, count, in_ready} !== 5'b00000) begin nbad++; $display("FAIL mid_idle got=%b exp=00000", {mem_we, count, in_ready}); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_back_to_back();
        test_encodings();
        test_errors();
        test_full();
        test_start_finish();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
